// File: rtl/grad_descent_top.sv
// rtl/grad_descent_top.sv - Q24.8 gradient-descent engine for z = (a-3)^2 + (b+2)^2 + (c-1)^2 + (d-4)^2
// Optional convergence-based early stop: define GD_EARLY_STOP_EN.
module grad_descent_top #(
  parameter int unsigned        NUM_ITERATIONS   = 50,
  parameter logic signed [31:0] LEARNING_RATE_A  = 32'h00000010,
  parameter logic signed [31:0] LEARNING_RATE_B  = 32'h00000010,
  parameter logic signed [31:0] LEARNING_RATE_C  = 32'h00000010,
  parameter logic signed [31:0] LEARNING_RATE_D  = 32'h00000001,
  parameter logic signed [31:0] LOWER_CONV_BOUND = 32'hFFFFFFC0,
  parameter logic signed [31:0] UPPER_CONV_BOUND = 32'h00000040
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_op,
  input  logic signed [7:0]  a_initial,
  input  logic signed [7:0]  b_initial,
  input  logic signed [7:0]  c_initial,
  input  logic signed [7:0]  d_initial,
  output logic signed [31:0] z_min,
  output logic signed [7:0]  final_a_at_min,
  output logic signed [7:0]  final_b_at_min,
  output logic signed [7:0]  final_c_at_min,
  output logic signed [7:0]  final_d_at_min,
  output logic               done_op
);

  typedef enum logic [2:0] {IDLE, LOAD, GRAD, UPDATE, EVAL, DONE} state_t;

  // Element 0..3 = a..d
  localparam logic [3:0][31:0] TARGET = {32'h00000400, 32'h00000100, 32'hFFFFFE00, 32'h00000300};
  localparam logic [3:0][31:0] LR     = {LEARNING_RATE_D, LEARNING_RATE_C, LEARNING_RATE_B, LEARNING_RATE_A};

  state_t            state, state_next;
  logic [3:0][31:0]  x;
  logic [3:0][31:0]  grad;
  logic [31:0]       iter_count;
  logic              converged;
  logic [3:0][7:0]   fin;

  logic [3:0][31:0]  diff, grad_next, step, rs;
  logic [3:0][63:0]  prod, sq;
  logic [3:0][7:0]   fin_next;
  logic [31:0]       z_next;
  logic              conv_next;
  logic              last_iter;

  function automatic logic [31:0] seed_q(input logic [7:0] s);
    return {{16{s[7]}}, s, 8'h00};
  endfunction

  always_comb begin
    conv_next = 1'b1;
    z_next    = '0;
    diff      = '0;
    grad_next = '0;
    step      = '0;
    rs        = '0;
    prod      = '0;
    sq        = '0;
    fin_next  = '0;
    for (int i = 0; i < 4; i++) begin
      diff[i]      = x[i] - TARGET[i];
      grad_next[i] = diff[i] << 1;
      conv_next    = conv_next && ($signed(grad_next[i]) >= LOWER_CONV_BOUND)
                               && ($signed(grad_next[i]) <= UPPER_CONV_BOUND);
      prod[i]      = 64'($signed(LR[i])) * 64'($signed(grad[i]));
      step[i]      = 32'(prod[i] >> 8);
      sq[i]        = 64'($signed(diff[i])) * 64'($signed(diff[i]));
      z_next       = z_next + 32'(sq[i] >> 8);
      // Round half up to the nearest integer, then clamp into the 8-bit result range
      rs[i]        = 32'($signed(x[i] + 32'h00000080) >>> 8);
      if ($signed(rs[i]) > 32'sd127)
        fin_next[i] = 8'h7F;
      else if ($signed(rs[i]) < -32'sd128)
        fin_next[i] = 8'h80;
      else
        fin_next[i] = rs[i][7:0];
    end
  end

  assign last_iter = (iter_count == NUM_ITERATIONS);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start_op) state_next = LOAD;
      LOAD:   state_next = GRAD;
      // The final GRAD pass refreshes converged for the point being reported
`ifdef GD_EARLY_STOP_EN
      GRAD:   state_next = (conv_next || last_iter) ? EVAL : UPDATE;
`else
      GRAD:   state_next = last_iter ? EVAL : UPDATE;
`endif
      UPDATE: state_next = GRAD;
      EVAL:   state_next = DONE;
      DONE:   if (done_op && !start_op) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      grad       <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      z_min      <= '0;
      fin        <= '0;
      done_op    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          x          <= {seed_q(d_initial), seed_q(c_initial), seed_q(b_initial), seed_q(a_initial)};
          iter_count <= '0;
          converged  <= 1'b0;
        end
        GRAD: begin
          grad      <= grad_next;
          converged <= conv_next;
        end
        UPDATE: begin
          for (int i = 0; i < 4; i++) x[i] <= x[i] - step[i];
          iter_count <= iter_count + 32'd1;
        end
        EVAL: begin
          z_min <= z_next;
          fin   <= fin_next;
        end
        DONE: begin
          // done_op is guaranteed one high cycle even if start_op already dropped
          if (!done_op)
            done_op <= 1'b1;
          else if (!start_op)
            done_op <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign final_a_at_min = fin[0];
  assign final_b_at_min = fin[1];
  assign final_c_at_min = fin[2];
  assign final_d_at_min = fin[3];

endmodule

// File: tb/tb_grad_descent_top.sv
// tb/tb_grad_descent_top.sv - scoreboard bench for grad_descent_top (three parameterisations)
module tb_grad_descent_top;

  typedef struct {
    logic [31:0] z;
    logic [31:0] fin;
    logic [31:0] it;
    logic        cv;
    bit          chk_z;
    bit          chk_cv;
  } exp_t;

`ifdef GD_EARLY_STOP_EN
  localparam int IT_OPT50 = 0;
  localparam int IT_OPT4  = 0;
  localparam int LAT_N4   = 4;
`else
  localparam int IT_OPT50 = 50;
  localparam int IT_OPT4  = 4;
  localparam int LAT_N4   = 12;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [7:0]  sa = 8'd0, sb = 8'd0, sc = 8'd0, sd = 8'd0;
  logic [2:0]  done_o;
  logic [31:0] z_o   [3];
  logic [31:0] fin_o [3];
  logic [31:0] it_o  [3];
  logic [2:0]  cv_o;

  int checks = 0;
  int errors = 0;
  exp_t sbq [3][$];

  always #5 clk = ~clk;

  grad_descent_top dut0 (
    .clk(clk), .rst_n(rst_n), .start_op(start[0]),
    .a_initial(sa), .b_initial(sb), .c_initial(sc), .d_initial(sd),
    .z_min(z_o[0]),
    .final_a_at_min(fin_o[0][7:0]), .final_b_at_min(fin_o[0][15:8]),
    .final_c_at_min(fin_o[0][23:16]), .final_d_at_min(fin_o[0][31:24]),
    .done_op(done_o[0])
  );

  grad_descent_top #(.LEARNING_RATE_D(32'h00000010)) dut_lr (
    .clk(clk), .rst_n(rst_n), .start_op(start[1]),
    .a_initial(sa), .b_initial(sb), .c_initial(sc), .d_initial(sd),
    .z_min(z_o[1]),
    .final_a_at_min(fin_o[1][7:0]), .final_b_at_min(fin_o[1][15:8]),
    .final_c_at_min(fin_o[1][23:16]), .final_d_at_min(fin_o[1][31:24]),
    .done_op(done_o[1])
  );

  grad_descent_top #(.NUM_ITERATIONS(4)) dut_n4 (
    .clk(clk), .rst_n(rst_n), .start_op(start[2]),
    .a_initial(sa), .b_initial(sb), .c_initial(sc), .d_initial(sd),
    .z_min(z_o[2]),
    .final_a_at_min(fin_o[2][7:0]), .final_b_at_min(fin_o[2][15:8]),
    .final_c_at_min(fin_o[2][23:16]), .final_d_at_min(fin_o[2][31:24]),
    .done_op(done_o[2])
  );

  assign it_o[0] = dut0.iter_count;
  assign it_o[1] = dut_lr.iter_count;
  assign it_o[2] = dut_n4.iter_count;
  assign cv_o    = {dut_n4.converged, dut_lr.converged, dut0.converged};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] z, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input int it,
                              input logic cv, input bit cz, input bit ccv);
    exp_t e;
    e.z = z; e.fin = {d, c, b, a}; e.it = it; e.cv = cv; e.chk_z = cz; e.chk_cv = ccv;
    return e;
  endfunction

  task automatic wait_done(input int idx, input int budget);
    int n = 0;
    while (!done_o[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen%0d", idx), {31'b0, done_o[idx]}, 32'd1);
  endtask

  initial begin : monitor
    logic [2:0] prev;
    exp_t e;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n && done_o[i] && !prev[i]) begin
          if (sbq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done%0d: got done_op=1 expected no result", i);
          end else begin
            e = sbq[i].pop_front();
            if (e.chk_z) check($sformatf("z_min%0d", i), z_o[i], e.z);
            check($sformatf("finals%0d", i), fin_o[i], e.fin);
            check($sformatf("iter_count%0d", i), it_o[i], e.it);
            if (e.chk_cv) check($sformatf("converged%0d", i), {31'b0, cv_o[i]}, {31'b0, e.cv});
          end
        end
      end
      prev = rst_n ? done_o : 3'b000;
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    check("rst_done", {29'b0, done_o}, 32'd0);
    check("rst_z", z_o[0], 32'd0);
    check("rst_fin", fin_o[0], 32'd0);
    check("rst_iter", it_o[0], 32'd0);
    check("rst_conv", {29'b0, cv_o}, 32'd0);
    rst_n = 1'b1;

    // Seeds zero, default rates; mid-run seed change must be ignored
    sbq[0].push_back(mk(32'h000006E9, 8'd3, 8'hFE, 8'd1, 8'd1, 50, 1'b0, 1'b1, 1'b1));
    start[0] = 1'b1;
    repeat (10) @(negedge clk);
    sa = 8'd55; sb = 8'h9C;
    wait_done(0, 300);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_done", {31'b0, done_o[0]}, 32'd1);
    end
    sa = 8'd3; sb = 8'hFE; sc = 8'd1; sd = 8'd4;
    start[0] = 1'b0;
    @(negedge clk);
    check("drop_done", {31'b0, done_o[0]}, 32'd0);

    // Seeds already at the optimum
    sbq[0].push_back(mk(32'h0, 8'd3, 8'hFE, 8'd1, 8'd4, IT_OPT50, 1'b1, 1'b1, 1'b1));
    start[0] = 1'b1;
    wait_done(0, 300);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Extreme seeds, equal rates, start only pulsed
    sa = 8'h7F; sb = 8'h80; sc = 8'h7F; sd = 8'h80;
    sbq[1].push_back(mk(32'h0, 8'd3, 8'hFE, 8'd1, 8'd4, 50, 1'b0, 1'b0, 1'b0));
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    sa = 8'd0; sb = 8'd0; sc = 8'd0; sd = 8'd0;
    wait_done(1, 300);
    @(negedge clk);
    check("pulse_clear", {31'b0, done_o[1]}, 32'd0);

    // Latency with NUM_ITERATIONS=4
    sa = 8'd3; sb = 8'hFE; sc = 8'd1; sd = 8'd4;
    sbq[2].push_back(mk(32'h0, 8'd3, 8'hFE, 8'd1, 8'd4, IT_OPT4, 1'b1, 1'b1, 1'b1));
    start[2] = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done_o[2] && n < 50);
    check("latency_n4", n, LAT_N4);
    start[2] = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-iteration, then a fresh run with start still high
    sa = 8'd0; sb = 8'd0; sc = 8'd0; sd = 8'd0;
    start[0] = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("areset_done", {31'b0, done_o[0]}, 32'd0);
    check("areset_fin", fin_o[0], 32'd0);
    check("areset_iter", it_o[0], 32'd0);
    check("areset_z", z_o[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sbq[0].push_back(mk(32'h000006E9, 8'd3, 8'hFE, 8'd1, 8'd1, 50, 1'b0, 1'b1, 1'b1));
    wait_done(0, 300);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) check($sformatf("queue_empty%0d", i), sbq[i].size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
